// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit-FIFO arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int BYTE_CNT_W  = 7;
  localparam int STALL_CNT_W = 10;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_MAX_LEN = 64;
  localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the write side of the shared transmit FIFO.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tdata;
  logic               twrreq;
  logic               tfull;

  // Environment side: requesters and the FIFO full flag.
  modport master (
    output req_valid, req_data, req_last, tfull,
    input  req_ready, tdata, twrreq
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, tfull,
    output req_ready, tdata, twrreq
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr+1, wrapping.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld,
  output logic [IDW-1:0]   idx
);

  int cand;

  always_comb begin
    gnt  = '0;
    vld  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one transmit FIFO; 1-cycle arbitration, zero-latency pass-through.
// tfull stalls the owner without counting as a stall; ownership ends on last, MAX_LEN bytes or TIMEOUT idle cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             err_pulse,
  output logic [IDW-1:0]   err_id
);

  arb_state_t             state, state_nxt;
  logic [N_REQ-1:0]       gnt_nxt;
  logic [IDW-1:0]         owner, owner_nxt;
  logic [IDW-1:0]         last_winner, last_winner_nxt;
  logic [IDW-1:0]         err_id_nxt;
  logic                   err_pulse_nxt;
  logic [BYTE_CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_nxt;

  logic [N_REQ-1:0]       pick_gnt;
  logic                   pick_vld;
  logic [IDW-1:0]         pick_idx;

  logic                   own_valid;
  logic                   own_last;
  logic                   accept;
  logic                   len_hit;
  logic                   stall_hit;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req (bus.req_valid),
    .ptr (last_winner),
    .gnt (pick_gnt),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // gnt is zero in IDLE, so masking with it also selects nothing outside a packet.
  assign own_valid = |(bus.req_valid & gnt);
  assign own_last  = |(bus.req_last & gnt);
  assign accept    = (state == XFER) && !bus.tfull && own_valid;

  assign bus.req_ready = ((state == XFER) && !bus.tfull) ? gnt : '0;
  assign bus.twrreq    = accept;
  assign bus.tdata     = bus.req_data[{owner, 3'b000} +: 8];

  assign len_hit   = (int'(byte_cnt) + 1) == MAX_LEN;
  assign stall_hit = (int'(stall_cnt) + 1) == TIMEOUT;
  assign busy      = (state == XFER);

  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    owner_nxt       = owner;
    last_winner_nxt = last_winner;
    err_pulse_nxt   = 1'b0;
    err_id_nxt      = err_id;
    byte_cnt_nxt    = byte_cnt;
    stall_cnt_nxt   = stall_cnt;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt     = XFER;
          gnt_nxt       = pick_gnt;
          owner_nxt     = pick_idx;
          byte_cnt_nxt  = '0;
          stall_cnt_nxt = '0;
        end
      end

      XFER: begin
        if (accept) begin
          byte_cnt_nxt  = byte_cnt + 1'b1;
          stall_cnt_nxt = '0;
          // A last byte that also hits the length limit is a clean end of packet.
          if (own_last || len_hit) begin
            state_nxt       = IDLE;
            gnt_nxt         = '0;
            last_winner_nxt = owner;
            if (!own_last) begin
              err_pulse_nxt = 1'b1;
              err_id_nxt    = owner;
            end
          end
        end else if (!own_valid) begin
          if (stall_hit) begin
            state_nxt       = IDLE;
            gnt_nxt         = '0;
            last_winner_nxt = owner;
            err_pulse_nxt   = 1'b1;
            err_id_nxt      = owner;
          end else begin
            stall_cnt_nxt = stall_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      last_winner <= IDW'(N_REQ - 1);
      err_pulse   <= 1'b0;
      err_id      <= '0;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      owner       <= owner_nxt;
      last_winner <= last_winner_nxt;
      err_pulse   <= err_pulse_nxt;
      err_id      <= err_id_nxt;
      byte_cnt    <= byte_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of byte-stream requesters sharing one transmit FIFO.
REQ-002 Parameter MAX_LEN, default 64, SHALL set the maximum bytes per packet before forced release.
REQ-003 Parameter TIMEOUT, default 1023, SHALL set the mid-packet stall limit in clk cycles.
REQ-004 clk  in  1  system clock; the single clock of the block.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  N_REQ  per-requester byte valid.
REQ-007 req_data  in  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  in  N_REQ  per-requester last-byte-of-packet flag.
REQ-009 req_ready  out  N_REQ  per-requester byte accepted this cycle when ANDed with req_valid.
REQ-010 tdata  out  8  byte to the transmit FIFO data port.
REQ-011 twrreq  out  1  transmit FIFO write strobe.
REQ-012 tfull  in  1  transmit FIFO full flag, write side.
REQ-013 gnt  out  N_REQ  one-hot current owner; all zero when no owner.
REQ-014 busy  out  1  high while a packet is owned.
REQ-015 err_pulse  out  1  one-cycle strobe on forced release.
REQ-016 err_id  out  $clog2(N_REQ)  index of the requester released by the last error; holds until the next error.

Function
REQ-017 The FSM SHALL have states IDLE and XFER only.
REQ-018 In IDLE with any req_valid set, the block SHALL register gnt to the round-robin winner and enter XFER next cycle; arbitration costs exactly 1 cycle.
REQ-019 Round-robin SHALL search from index (last_winner+1) mod N_REQ upward with wrap; last_winner SHALL reset to N_REQ-1, so requester 0 has first priority.
REQ-020 In XFER, req_ready[g] SHALL equal !tfull for owner g; every other bit SHALL be 0; req_ready SHALL be all 0 in IDLE.
REQ-021 twrreq SHALL equal req_valid[g] & req_ready[g] combinationally; tdata SHALL equal req_data of g; there is zero-cycle latency from accept to FIFO write.
REQ-022 twrreq SHALL never assert while tfull is high; no write is dropped or duplicated.
REQ-023 A 7-bit byte counter SHALL clear on entering XFER and increment per accepted byte.
REQ-024 An accepted byte with req_last set SHALL end the packet: next cycle the FSM is in IDLE, gnt is 0, and last_winner is g.
REQ-025 If the counter reaches MAX_LEN without req_last, the FSM SHALL force release after that byte: err_pulse=1 for 1 cycle, err_id=g, last_winner=g.
REQ-026 A 10-bit stall counter SHALL count XFER cycles where req_valid[g]=0; it SHALL clear on any accept. Cycles blocked only by tfull SHALL NOT count.
REQ-027 When the stall counter reaches TIMEOUT, the block SHALL force release with err_pulse and err_id as in REQ-025.
REQ-028 If req_last and the MAX_LEN limit coincide on the same byte, the release SHALL be normal with no err_pulse.
REQ-029 A requester that drops valid without an accept SHALL keep gnt until last, MAX_LEN or timeout.
REQ-030 After a forced release, the block SHALL re-grant the same requester only if no other requester is valid.
REQ-031 busy SHALL equal (state==XFER).

Reset
REQ-032 On rst_n low, the block SHALL asynchronously set state=IDLE, gnt=0, busy=0, err_pulse=0, err_id=0, both counters=0 and last_winner=N_REQ-1.
REQ-033 req_ready and twrreq SHALL be 0 during reset; reset mid-packet SHALL abandon the packet with no further FIFO writes.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the state enum, the byte-counter and stall-counter widths, and the default parameter constants.
REQ-035 Sub-module rr_picker (combinational: request vector + pointer -> one-hot grant + valid) SHALL implement REQ-019.

Verification
REQ-036 Req0 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) with tfull=0 -> gnt=0001 from cycle 2, three consecutive twrreq with matching tdata, IDLE on cycle 5.
REQ-037 All 4 requesters hold 1-byte last packets -> grant order 0,1,2,3,0; each grant is separated by one IDLE cycle.
REQ-038 Req1 is mid-packet and tfull is held high for 50 cycles -> twrreq=0 and req_ready=0 throughout, no err_pulse, bytes resume unchanged after tfull falls.
REQ-039 Req2 streams 64 bytes with no last -> 64 writes, then err_pulse for 1 cycle, err_id=2, gnt=0.
REQ-040 Req3 is granted and its valid stays low for 1023 cycles -> err_pulse, err_id=3; a waiting req0 is granted next.
REQ-041 rst_n is pulsed low mid-packet -> all outputs return to reset values immediately, and after release req0 wins first arbitration.
